uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter; the transmit-side counterpart of the team's oversampled UART receiver and sharing its timing model.
- clk_in runs at baud rate × OVERSAMPLING; each serial bit is held for exactly OVERSAMPLING clk_in cycles.
- Takes parallel words through a valid/ready handshake and serialises them LSB-first with start and stop framing.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- OVERSAMPLING, 8, clk_in cycles per serial bit (>=2).
- DATA_BITS, 8, data bits per frame (5..9).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined.

Ports:
- clk_in  input  1  clock, baud × OVERSAMPLING.
- nrst_in  input  1  reset, asynchronous, active-low.
- tx_data_in  input  DATA_BITS  word to send.
- tx_valid_in  input  1  tx_data_in is valid.
- tx_ready_out  output  1  block can accept a word; equals holding register empty.
- tx_serial_out  output  1  serial line, registered, idle high.
- tx_busy_out  output  1  a frame is in progress (FSM not in IDLE).
- tx_done_out  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
Clock, reset and registers
- One clock: clk_in. Reset nrst_in is asynchronous, active-low.
- Reset values: tx_serial_out=1, tx_ready_out=1, tx_busy_out=0, tx_done_out=0; FSM=IDLE; bit counter, cycle counter, shift register and holding register cleared.
- Reset mid-frame: line returns high immediately (asynchronously), the frame is abandoned and the holding register contents are discarded.
- Cycle counter is $clog2(OVERSAMPLING) bits wide and counts 0..OVERSAMPLING-1. Bit index is wide enough for DATA_BITS-1, or STOP_BITS-1 when larger.

Handshake
- A word is accepted on a rising edge with tx_valid_in=1 and tx_ready_out=1.
- Accept while IDLE: word loads straight into the shift register; FSM goes to START; tx_serial_out is low from the next cycle (latency 1).
- Accept while not IDLE: word loads into the holding register; tx_ready_out drops the next cycle.
- tx_valid_in while tx_ready_out=0 is ignored; tx_data_in is not sampled.

FSM states (each bit lasts OVERSAMPLING cycles)
- IDLE: line=1.
- START: line=0; after OVERSAMPLING cycles go to DATA.
- DATA: line=shift[0]. Shift right at the end of each bit. After DATA_BITS bits go to PARITY (macro defined) or STOP.
- PARITY: line = parity bit; after OVERSAMPLING cycles go to STOP.
- STOP: line=1 for STOP_BITS × OVERSAMPLING cycles. At the final cycle:
  - holding register full: load shift register from it, clear holding, go to START. The next cycle is the start bit, with no idle cycle in between. tx_ready_out rises that cycle.
  - holding register empty: go to IDLE.

Completion and timing
- tx_done_out=1 for exactly the one cycle after the last stop cycle, i.e. the first cycle of IDLE or of the next START.
- Frame length = (1 + DATA_BITS + P + STOP_BITS) × OVERSAMPLING cycles, where P=1 with the macro and 0 without.
- Holding register drain and a new accept cannot coincide, because tx_ready_out=0 while the holding register is full.
- Illegal state encoding: go to IDLE with line=1.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted after DATA.
  - Parity bit = XOR of the data bits when PARITY_ODD=0, its inverse when PARITY_ODD=1.
  - Parity is computed from the word when it is loaded into the shift register.
- Not defined: no PARITY state, no parity logic; PARITY_ODD is ignored; DATA goes directly to STOP.

Test Plan:
1. Defaults, send 0x55 from IDLE:
   - line low for cycles 1-8, then 1,0,1,0,1,0,1,0 for 8 cycles each, then high for 8 cycles.
   - tx_busy_out high 80 cycles; tx_done_out pulses at cycle 81.
2. Back-to-back: send 0xA5, then 0x3C while busy (valid held):
   - 0x3C accepted into the holding register; tx_ready_out=0 until 0xA5's stop bit ends.
   - 0x3C start bit directly follows 0xA5's stop bit with zero idle cycles; two done pulses 80 cycles apart.
3. Third word 0xFF offered while the holding register is full:
   - tx_ready_out=0; word ignored; only 0xA5 and 0x3C appear on the line.
4. nrst_in pulsed low during data bit 3 of 0xFF:
   - tx_serial_out=1 immediately; tx_ready_out=1, tx_busy_out=0.
   - After release, 0x00 is sent as a correct 80-cycle frame.
5. STOP_BITS=2, send 0x80: frame is 88 cycles; line high for the final 16 cycles.
6. UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07: parity bit=1, frame 88 cycles. With PARITY_ODD=1: parity bit=0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- oversampled UART transmitter.
//
// Serialises DATA_BITS-wide words LSB-first as: start bit (0), data bits,
// optional parity bit, STOP_BITS stop bits (1). Every serial bit is held for
// exactly OVERSAMPLING clk_in cycles. A one-entry holding register lets a
// second word be queued during a frame so frames can run back to back.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit follows the data bits (even, or odd when
//                PARITY_ODD=1), computed when the word enters the shifter.
//   undefined -> no parity bit; PARITY_ODD has no effect.
//
// Ports:
//   clk_in         clock, baud rate x OVERSAMPLING
//   nrst_in        asynchronous active-low reset
//   tx_data_in     word to send
//   tx_valid_in    tx_data_in is valid
//   tx_ready_out   a word can be accepted (holding register empty)
//   tx_serial_out  registered serial line, idle high
//   tx_busy_out    a frame is in progress
//   tx_done_out    one-cycle pulse after a frame's last stop cycle
module uart_tx #(
   parameter int OVERSAMPLING = 8,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk_in,
   input  logic                 nrst_in,
   input  logic [DATA_BITS-1:0] tx_data_in,
   input  logic                 tx_valid_in,
   output logic                 tx_ready_out,
   output logic                 tx_serial_out,
   output logic                 tx_busy_out,
   output logic                 tx_done_out
);

   localparam int CNT_W   = $clog2(OVERSAMPLING);
   localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS - 1 : STOP_BITS - 1;
   localparam int IDX_W   = (IDX_MAX < 1) ? 1 : $clog2(IDX_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLING - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   if (OVERSAMPLING < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx: parameter out of range");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic                   serial_q, serial_d;
   logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   logic                   accept;
   logic                   bit_end;
   logic                   load;
   logic [DATA_BITS-1:0]   load_word;

   assign accept  = tx_valid_in & ~hold_full_q;
   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      load        = 1'b0;
      load_word   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            // A word left in the holding register (queued just as the last
            // frame ended) is drained before any new word is taken.
            if (hold_full_q) begin
               load        = 1'b1;
               load_word   = hold_q;
               hold_d      = '0;
               hold_full_d = 1'b0;
            end else if (accept) begin
               load      = 1'b1;
               load_word = tx_data_in;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == DATA_LAST) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == STOP_LAST) begin
                  done_d = 1'b1;
                  idx_d  = '0;
                  if (hold_full_q) begin
                     load        = 1'b1;
                     load_word   = hold_q;
                     hold_d      = '0;
                     hold_full_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Accept into the holding register during a frame. Cannot collide
      // with a drain above, since accept requires the register to be empty.
      if (accept && state_q != S_IDLE) begin
         hold_d      = tx_data_in;
         hold_full_d = 1'b1;
      end

      if (load) begin
         shift_d = load_word;
         state_d = S_START;
         cnt_d   = '0;
         idx_d   = '0;
`ifdef UART_TX_PARITY_EN
         parity_d = (^load_word) ^ (PARITY_ODD != 0);
`endif
      end

      // The line register is loaded from the next state so each bit
      // appears on tx_serial_out for the full duration of that state.
      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = parity_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         serial_q    <= 1'b1;
         done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         serial_q    <= serial_d;
         done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign tx_ready_out  = ~hold_full_q;
   assign tx_serial_out = serial_q;
   assign tx_busy_out   = (state_q != S_IDLE);
   assign tx_done_out   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
// dut0: defaults, dut1: STOP_BITS=2, dut2: PARITY_ODD=1.
// Words are pushed to exp_q when driven and popped when a frame is decoded.
module tb_uart_tx;

   localparam int OS = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME_1S = (1 + 8 + P + 1) * OS;
   localparam int FRAME_2S = (1 + 8 + P + 2) * OS;

   logic            clk = 1'b0;
   logic            nrst;
   logic [2:0]      valid;
   logic [2:0][7:0] data;
   logic [2:0]      ser, rdy, busy, done;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  expw;

   // Results of the most recent rx_frame call.
   logic        r_got, r_start, r_par, r_stop_ok, r_done_first;
   logic [7:0]  r_word;
   int          r_wait, r_unstable, r_busy;

   always #5 clk = ~clk;

   uart_tx #(.OVERSAMPLING(OS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
      .clk_in(clk), .nrst_in(nrst), .tx_data_in(data[0]), .tx_valid_in(valid[0]),
      .tx_ready_out(rdy[0]), .tx_serial_out(ser[0]), .tx_busy_out(busy[0]), .tx_done_out(done[0]));

   uart_tx #(.OVERSAMPLING(OS), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
      .clk_in(clk), .nrst_in(nrst), .tx_data_in(data[1]), .tx_valid_in(valid[1]),
      .tx_ready_out(rdy[1]), .tx_serial_out(ser[1]), .tx_busy_out(busy[1]), .tx_done_out(done[1]));

   uart_tx #(.OVERSAMPLING(OS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
      .clk_in(clk), .nrst_in(nrst), .tx_data_in(data[2]), .tx_valid_in(valid[2]),
      .tx_ready_out(rdy[2]), .tx_serial_out(ser[2]), .tx_busy_out(busy[2]), .tx_done_out(done[2]));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input int w, input logic [7:0] d);
      data[w]  = d;
      valid[w] = 1'b1;
      @(posedge clk);
      #1;
      valid[w] = 1'b0;
   endtask

   // Waits up to budget cycles for a start bit, then samples every cycle of
   // the frame on the falling edge and decodes it.
   task automatic rx_frame(input int w, input int stop_bits, input int budget);
      logic v, first;
      logic bits [16];
      int   nbits;
      r_got = 1'b0; r_wait = 0; r_unstable = 0; r_busy = 0; r_done_first = 1'b0;
      r_word = '0; r_par = 1'b0; r_stop_ok = 1'b0; r_start = 1'b1;
      while (!r_got && r_wait < budget) begin
         @(negedge clk);
         r_wait++;
         if (ser[w] === 1'b0) r_got = 1'b1;
      end
      if (!r_got) return;
      r_done_first = done[w];
      nbits = 1 + 8 + P + stop_bits;
      first = 1'b0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < OS; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            v = ser[w];
            if (busy[w] === 1'b1) r_busy++;
            if (c == 0) begin
               first   = v;
               bits[b] = v;
            end else if (v !== first) begin
               r_unstable++;
            end
         end
      end
      r_start = bits[0];
      for (int i = 0; i < 8; i++) r_word[i] = bits[1 + i];
      r_par = (P == 1) ? bits[9] : 1'b0;
      r_stop_ok = 1'b1;
      for (int s = 0; s < stop_bits; s++)
         if (bits[9 + P + s] !== 1'b1) r_stop_ok = 1'b0;
   endtask

   task automatic test_reset();
      nrst  = 1'b0;
      valid = '0;
      data  = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ser !== 3'b111) begin errors++; $display("FAIL reset_serial: got %b required 111", ser); end
      checks++; if (rdy !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b required 111", rdy); end
      checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b required 000", busy); end
      checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b required 000", done); end
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      send(0, 8'h55);
      exp_q.push_back(8'h55);
      rx_frame(0, 1, 4);
      checks++; if (r_got !== 1'b1 || r_wait != 1) begin errors++; $display("FAIL single_latency: got found=%b wait=%0d required found=1 wait=1", r_got, r_wait); end
      checks++; if (r_start !== 1'b0) begin errors++; $display("FAIL single_start: got %b required 0", r_start); end
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_word !== expw) begin errors++; $display("FAIL single_word: got %h required %h", r_word, expw); end
      checks++; if (r_unstable != 0) begin errors++; $display("FAIL single_bit_hold: got %0d glitches required 0", r_unstable); end
      checks++; if (r_stop_ok !== 1'b1) begin errors++; $display("FAIL single_stop: got %b required 1", r_stop_ok); end
      checks++; if (r_busy != FRAME_1S) begin errors++; $display("FAIL single_busy_len: got %0d required %0d", r_busy, FRAME_1S); end
`ifdef UART_TX_PARITY_EN
      checks++; if (r_par !== ^expw) begin errors++; $display("FAIL single_parity: got %b required %b", r_par, ^expw); end
`endif
      @(negedge clk);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL single_done_pulse: got %b required 1", done[0]); end
      checks++; if (busy[0] !== 1'b0 || ser[0] !== 1'b1) begin errors++; $display("FAIL single_idle_after: got busy=%b line=%b required busy=0 line=1", busy[0], ser[0]); end
      @(negedge clk);
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b required 0", done[0]); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w1;
      logic       s1, st1, df1;
      int         u1;
      fork
         begin
            send(0, 8'hA5);
            exp_q.push_back(8'hA5);
            checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_first: got %b required 1", rdy[0]); end
            send(0, 8'h3C);
            exp_q.push_back(8'h3C);
            checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_hold_full: got %b required 0", rdy[0]); end
            // Offered while the holding register is full: must be ignored.
            data[0]  = 8'hFF;
            valid[0] = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL full_ignore_ready: got %b required 0", rdy[0]); end
            valid[0] = 1'b0;
         end
         begin
            rx_frame(0, 1, 4);
            w1 = r_word; s1 = r_stop_ok; st1 = r_start; u1 = r_unstable; df1 = r_done_first;
            rx_frame(0, 1, 1);
         end
      join
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (w1 !== expw || st1 !== 1'b0 || s1 !== 1'b1 || u1 != 0) begin errors++; $display("FAIL b2b_frame1: got word=%h start=%b stop=%b glitches=%0d required word=%h start=0 stop=1 glitches=0", w1, st1, s1, u1, expw); end
      checks++; if (df1 !== 1'b0) begin errors++; $display("FAIL b2b_done_frame1_start: got %b required 0", df1); end
      checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got found=%b required found=1 with zero idle cycles", r_got); end
      checks++; if (r_done_first !== 1'b1) begin errors++; $display("FAIL b2b_done_at_start2: got %b required 1", r_done_first); end
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_word !== expw || r_stop_ok !== 1'b1 || r_unstable != 0) begin errors++; $display("FAIL b2b_frame2: got word=%h stop=%b glitches=%0d required word=%h stop=1 glitches=0", r_word, r_stop_ok, r_unstable, expw); end
      checks++; if (r_busy != FRAME_1S) begin errors++; $display("FAIL b2b_busy_len2: got %0d required %0d", r_busy, FRAME_1S); end
      @(negedge clk);
      checks++; if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_done2: got done=%b busy=%b required done=1 busy=0", done[0], busy[0]); end
      rx_frame(0, 1, 2 * FRAME_1S);
      checks++; if (r_got !== 1'b0) begin errors++; $display("FAIL full_ignore_no_frame: got extra frame word=%h required none", r_word); end
   endtask

   task automatic test_reset_mid_frame();
      send(0, 8'hFF);
      send(0, 8'h11);
      checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL rst_hold_loaded: got %b required 0", rdy[0]); end
      // Start bit occupies cycles 1-8; data bit 3 occupies cycles 33-40.
      repeat (34) @(negedge clk);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b required 1", busy[0]); end
      #1 nrst = 1'b0;
      #1;
      checks++; if (ser[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin errors++; $display("FAIL rst_async: got line=%b ready=%b busy=%b required 1 1 0", ser[0], rdy[0], busy[0]); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      rx_frame(0, 1, 20);
      checks++; if (r_got !== 1'b0) begin errors++; $display("FAIL rst_hold_discard: got frame word=%h required none", r_word); end
      @(posedge clk);
      #1;
      send(0, 8'h00);
      exp_q.push_back(8'h00);
      rx_frame(0, 1, 4);
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_got !== 1'b1 || r_word !== expw || r_stop_ok !== 1'b1 || r_unstable != 0) begin errors++; $display("FAIL rst_after_frame: got found=%b word=%h stop=%b glitches=%0d required 1 %h 1 0", r_got, r_word, r_stop_ok, r_unstable, expw); end
      checks++; if (r_busy != FRAME_1S) begin errors++; $display("FAIL rst_after_len: got %0d required %0d", r_busy, FRAME_1S); end
      @(negedge clk);
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL rst_after_done: got %b required 1", done[0]); end
   endtask

   task automatic test_two_stop();
      send(1, 8'h80);
      exp_q.push_back(8'h80);
      rx_frame(1, 2, 4);
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_got !== 1'b1 || r_wait != 1 || r_word !== expw) begin errors++; $display("FAIL stop2_word: got found=%b wait=%0d word=%h required 1 1 %h", r_got, r_wait, r_word, expw); end
      checks++; if (r_stop_ok !== 1'b1 || r_unstable != 0) begin errors++; $display("FAIL stop2_stop_bits: got stop=%b glitches=%0d required 1 0", r_stop_ok, r_unstable); end
      checks++; if (r_busy != FRAME_2S) begin errors++; $display("FAIL stop2_len: got %0d required %0d", r_busy, FRAME_2S); end
      @(negedge clk);
      checks++; if (done[1] !== 1'b1 || busy[1] !== 1'b0) begin errors++; $display("FAIL stop2_done: got done=%b busy=%b required 1 0", done[1], busy[1]); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      send(0, 8'h07);
      exp_q.push_back(8'h07);
      rx_frame(0, 1, 4);
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_word !== expw || r_par !== 1'b1) begin errors++; $display("FAIL parity_even: got word=%h par=%b required %h 1", r_word, r_par, expw); end
      checks++; if (r_busy != FRAME_1S || r_stop_ok !== 1'b1) begin errors++; $display("FAIL parity_even_len: got len=%0d stop=%b required %0d 1", r_busy, r_stop_ok, FRAME_1S); end
      repeat (2) @(negedge clk);
      send(2, 8'h07);
      exp_q.push_back(8'h07);
      rx_frame(2, 1, 4);
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r_word !== expw || r_par !== 1'b0) begin errors++; $display("FAIL parity_odd: got word=%h par=%b required %h 0", r_word, r_par, expw); end
      checks++; if (r_busy != FRAME_1S) begin errors++; $display("FAIL parity_odd_len: got %0d required %0d", r_busy, FRAME_1S); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_frame();
      test_two_stop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending words required 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
